out_change_fifo: RTL and testbench
==================================

Name: out_change_fifo

Overview:
- Downstream consumer of the 8-bit output bus of the counter/state-machine stage (FSM cycling phases 0->1->2 on CLK/RST_X).
- Samples that bus on a strobe and records only value changes into a small FIFO.
- Hands recorded values to the next stage over a valid/ready handshake.
- Decouples the combinational, glitch-prone FSM output from slower consumers and flags lost events.

Parameters:
- WIDTH, 8, data width of sampled bus and FIFO entries
- DEPTH, 4, FIFO entries; power of two, >= 2
- AW, 2, log2(DEPTH); pointer width

Ports:
- CLK  in  1  clock, all state on posedge
- RST_X  in  1  reset, asynchronous, active-low
- IN  in  WIDTH  sampled bus (upstream stage's output)
- IN_EN  in  1  sample strobe; bus is sampled only when high
- OUT  out  WIDTH  FIFO head data
- OUT_VALID  out  1  head entry valid
- OUT_READY  in  1  consumer accepts head
- COUNT  out  AW+1  current occupancy 0..DEPTH
- OVERFLOW  out  1  sticky lost-event flag
- OVF_CLR  in  1  clears OVERFLOW

Behaviour:
- Reset (RST_X low, async): capture FSM to WAIT_FIRST; prev=0; rd/wr pointers=0; COUNT=0; OUT=0; OUT_VALID=0; OVERFLOW=0. FIFO storage contents undefined; not reset. Releasing reset mid-transfer discards all entries.
- Capture FSM, two states:
  - WAIT_FIRST: on IN_EN, push IN, prev<=IN, go to TRACK.
  - TRACK: on IN_EN and IN!=prev, push IN, prev<=IN. On IN_EN and IN==prev, no push. Stays in TRACK until reset.
  - No IN_EN: no change in either state.
- prev updates on every qualifying sample, including dropped ones. A value lost to overflow is not re-pushed on the next equal sample.
- Push request: FIFO not full -> write at wr_ptr, wr_ptr+1 mod DEPTH. Full and no pop same cycle -> drop, OVERFLOW<=1.
- Pop: OUT_VALID && OUT_READY at posedge; rd_ptr+1 mod DEPTH. OUT_READY with OUT_VALID=0 is ignored.
- Simultaneous push and pop:
  - Full: pop frees a slot; push accepted; COUNT stays DEPTH; no overflow.
  - Empty: no pop, since OUT_VALID=0. Push accepted; COUNT=1.
- COUNT: +1 on push only, -1 on pop only, unchanged on both or neither. Never exceeds DEPTH, never below 0.
- OUT_VALID = (COUNT!=0). OUT = mem[rd_ptr], first-word-fall-through.
- Latency: sample at edge N is on OUT with OUT_VALID=1 in the cycle after edge N (1 cycle).
- OUT and OUT_VALID must hold stable while OUT_VALID=1 and OUT_READY=0.
- OVERFLOW: set on drop, cleared by OVF_CLR at posedge. Drop and OVF_CLR in the same cycle -> OVERFLOW=1 (set wins).
- Pointers wrap at DEPTH. Full/empty are distinguished by COUNT, not pointer equality.
- Arithmetic: equality compare only on IN. Pointer adds truncate to AW bits.

Optional Feature:
- Macro: OUT_CHANGE_FIFO_TS_EN.
- Defined:
  - Adds a free-running 8-bit counter tcnt (reset 0, +1 every cycle, wraps 255->0).
  - Each FIFO entry stores {tcnt at sample edge, IN}.
  - Adds port OUT_TS out 8, the head entry's timestamp. OUT_TS=0 at reset. Same valid/stable rules as OUT.
- Undefined: no counter, no OUT_TS port, entries WIDTH bits. All other behaviour identical.

Test Plan:
- Reset, then IN_EN=1 with IN=8'h00 one cycle -> OUT_VALID=1 next cycle, OUT=8'h00, COUNT=1.
- With OUT_READY=1, IN_EN=1 every cycle, IN sequence 0,0,9,9,9,1 -> exactly 3 outputs in order: 8'h00, 8'h09, 8'h01.
- With OUT_READY=0, push distinct values 1..5 (DEPTH=4) -> COUNT=4, OVERFLOW=1. Drain yields 1,2,3,4. Then OVF_CLR -> OVERFLOW=0.
- Full FIFO, same cycle push 8'h07 and OUT_READY=1 -> COUNT stays 4, OVERFLOW=0, 8'h07 emerges fourth.
- Assert RST_X low asynchronously mid-clock with COUNT=3 -> OUT_VALID=0, COUNT=0 immediately. Then first sample 8'h05 is pushed even though prev was 5 before reset.
- With OUT_CHANGE_FIFO_TS_EN: sample 8'h0A at the 11th posedge after reset release -> OUT_TS=8'd10 with OUT=8'h0A.

Source files
------------

// File: rtl/out_change_fifo.sv
// Change-only sampler: records IN whenever it differs from the last sample into a
// FWFT FIFO with a valid/ready output. Define OUT_CHANGE_FIFO_TS_EN to add per-entry timestamps.
module out_change_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic             CLK,
    input  logic             RST_X,
    input  logic [WIDTH-1:0] IN,
    input  logic             IN_EN,
    output logic [WIDTH-1:0] OUT,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [AW:0]      COUNT,
    output logic             OVERFLOW,
    input  logic             OVF_CLR
`ifdef OUT_CHANGE_FIFO_TS_EN
    ,
    output logic [7:0]       OUT_TS
`endif
);

    localparam logic [0:0] WAIT_FIRST = 1'b0;
    localparam logic [0:0] TRACK      = 1'b1;

    logic [0:0]       state;
    logic [WIDTH-1:0] prev;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             ovf;
    logic [WIDTH-1:0] mem [DEPTH];

    logic push_req;
    logic pop;
    logic full;
    logic push_ok;
    logic drop;

    always_comb begin
        push_req = IN_EN && ((state == WAIT_FIRST) || (IN != prev));
        pop      = OUT_VALID && OUT_READY;
        full     = (count == (AW+1)'(DEPTH));
        // A pop in the same cycle frees the slot the push is about to use.
        push_ok  = push_req && (!full || pop);
        drop     = push_req && full && !pop;
    end

    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            state <= WAIT_FIRST;
            prev  <= '0;
        end else if (IN_EN) begin
            state <= TRACK;
            prev  <= IN;
        end
    end

    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            if (push_ok && !pop)      count <= count + 1'b1;
            else if (!push_ok && pop) count <= count - 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X)       ovf <= 1'b0;
        else if (drop)    ovf <= 1'b1;
        else if (OVF_CLR) ovf <= 1'b0;
    end

    always_ff @(posedge CLK) begin
        if (push_ok) mem[wr_ptr] <= IN;
    end

    // Head is masked while empty so OUT reads zero out of reset despite unreset storage.
    always_comb begin
        OUT_VALID = (count != '0);
        OUT       = OUT_VALID ? mem[rd_ptr] : '0;
        COUNT     = count;
        OVERFLOW  = ovf;
    end

`ifdef OUT_CHANGE_FIFO_TS_EN
    logic [7:0] tcnt;
    logic [7:0] mem_ts [DEPTH];

    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) tcnt <= '0;
        else        tcnt <= tcnt + 8'd1;
    end

    always_ff @(posedge CLK) begin
        if (push_ok) mem_ts[wr_ptr] <= tcnt;
    end

    always_comb begin
        OUT_TS = OUT_VALID ? mem_ts[rd_ptr] : '0;
    end
`endif

endmodule

// File: tb/tb_out_change_fifo.sv
// Scoreboard bench for out_change_fifo: directed samples push expected outputs,
// a negedge monitor compares every accepted head against the queue.
module tb_out_change_fifo;

    logic       CLK = 1'b0;
    logic       RST_X = 1'b0;
    logic [7:0] IN = '0;
    logic       IN_EN = 1'b0;
    logic [7:0] OUT;
    logic       OUT_VALID;
    logic       OUT_READY = 1'b0;
    logic [2:0] COUNT;
    logic       OVERFLOW;
    logic       OVF_CLR = 1'b0;
`ifdef OUT_CHANGE_FIFO_TS_EN
    logic [7:0] OUT_TS;
`endif

    int         errors = 0;
    int         checks = 0;
    int         n_out  = 0;
    int         n_base;
    logic [7:0] expq [$];
    logic [7:0] expv;

    out_change_fifo #(.WIDTH(8), .DEPTH(4), .AW(2)) dut (
        .CLK       (CLK),
        .RST_X     (RST_X),
        .IN        (IN),
        .IN_EN     (IN_EN),
        .OUT       (OUT),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .COUNT     (COUNT),
        .OVERFLOW  (OVERFLOW),
        .OVF_CLR   (OVF_CLR)
`ifdef OUT_CHANGE_FIFO_TS_EN
        ,
        .OUT_TS    (OUT_TS)
`endif
    );

    always #5 CLK = ~CLK;

    // Monitor: every head accepted by the consumer must match the scoreboard front.
    always @(negedge CLK) begin
        if (OUT_VALID && OUT_READY) begin
            checks++;
            n_out++;
            if (expq.size() == 0) begin
                errors++;
                $display("FAIL monitor_extra: got OUT=%h, required no output", OUT);
            end else begin
                expv = expq.pop_front();
                if (OUT !== expv) begin
                    errors++;
                    $display("FAIL monitor_data: got OUT=%h, required %h", OUT, expv);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic sample(input logic [7:0] v);
        IN    = v;
        IN_EN = 1'b1;
        step();
    endtask

    task automatic do_reset();
        IN_EN     = 1'b0;
        OUT_READY = 1'b0;
        OVF_CLR   = 1'b0;
        @(posedge CLK);
        #3 RST_X = 1'b0;
        expq.delete();
        repeat (2) @(posedge CLK);
        #1 RST_X = 1'b1;
    endtask

    initial begin
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_valid", OUT_VALID, 0);
        chk("rst_count", COUNT, 0);
        chk("rst_out", OUT, 0);
        chk("rst_ovf", OVERFLOW, 0);
        RST_X = 1'b1;

        // First sample after reset is always pushed, visible one cycle later.
        expq.push_back(8'h00);
        sample(8'h00);
        IN_EN = 1'b0;
        chk("t1_valid", OUT_VALID, 1);
        chk("t1_out", OUT, 8'h00);
        chk("t1_count", COUNT, 1);
        OUT_READY = 1'b1;
        step();
        chk("t1_drained", COUNT, 0);

        // Change-only recording with a free-flowing consumer.
        do_reset();
        OUT_READY = 1'b1;
        expq.push_back(8'h00);
        expq.push_back(8'h09);
        expq.push_back(8'h01);
        n_base = n_out;
        sample(8'h00); sample(8'h00); sample(8'h09);
        sample(8'h09); sample(8'h09); sample(8'h01);
        IN_EN = 1'b0;
        repeat (3) step();
        chk("t2_outputs", n_out - n_base, 3);
        chk("t2_count", COUNT, 0);

        // Overflow: fifth distinct value is lost.
        do_reset();
        for (int unsigned v = 1; v <= 4; v++) expq.push_back(8'(v));
        for (int unsigned v = 1; v <= 5; v++) sample(8'(v));
        IN_EN = 1'b0;
        chk("t3_count_full", COUNT, 4);
        chk("t3_ovf_set", OVERFLOW, 1);
        chk("t3_head", OUT, 8'h01);
        OUT_READY = 1'b1;
        repeat (4) step();
        OUT_READY = 1'b0;
        chk("t3_count_drained", COUNT, 0);
        chk("t3_ovf_sticky", OVERFLOW, 1);
        OVF_CLR = 1'b1;
        step();
        OVF_CLR = 1'b0;
        chk("t3_ovf_clr", OVERFLOW, 0);

        // Full FIFO with simultaneous push and pop; prev is 5 (dropped sample still tracked).
        expq.push_back(8'h10);
        expq.push_back(8'h11);
        expq.push_back(8'h12);
        expq.push_back(8'h13);
        expq.push_back(8'h07);
        sample(8'h10); sample(8'h11); sample(8'h12); sample(8'h13);
        chk("t4_full", COUNT, 4);
        IN        = 8'h07;
        IN_EN     = 1'b1;
        OUT_READY = 1'b1;
        step();
        IN_EN     = 1'b0;
        OUT_READY = 1'b0;
        chk("t4_count_kept", COUNT, 4);
        chk("t4_no_ovf", OVERFLOW, 0);
        chk("t4_head", OUT, 8'h11);
        repeat (2) step();
        chk("t4_stall_out", OUT, 8'h11);
        chk("t4_stall_valid", OUT_VALID, 1);
        // Drop and clear in the same cycle: set wins.
        IN      = 8'h08;
        IN_EN   = 1'b1;
        OVF_CLR = 1'b1;
        step();
        IN_EN   = 1'b0;
        OVF_CLR = 1'b0;
        chk("t4_set_wins", OVERFLOW, 1);
        chk("t4_count_after_drop", COUNT, 4);
        OVF_CLR = 1'b1;
        step();
        OVF_CLR = 1'b0;
        chk("t4_ovf_clr", OVERFLOW, 0);
        OUT_READY = 1'b1;
        repeat (4) step();
        OUT_READY = 1'b0;
        chk("t4_count_empty", COUNT, 0);
        chk("t4_valid_empty", OUT_VALID, 0);
        chk("t4_out_empty", OUT, 0);

        // Asynchronous reset mid-cycle with three entries; prev ends at 5.
        expq.push_back(8'h03);
        expq.push_back(8'h04);
        expq.push_back(8'h05);
        sample(8'h03); sample(8'h04); sample(8'h05);
        IN_EN = 1'b0;
        chk("t5_count3", COUNT, 3);
        @(posedge CLK);
        #3 RST_X = 1'b0;
        #1;
        chk("t5_async_valid", OUT_VALID, 0);
        chk("t5_async_count", COUNT, 0);
        expq.delete();
        @(posedge CLK);
        #1 RST_X = 1'b1;
        expq.push_back(8'h05);
        sample(8'h05);
        IN_EN = 1'b0;
        chk("t5_repush_count", COUNT, 1);
        chk("t5_repush_out", OUT, 8'h05);
        OUT_READY = 1'b1;
        step();
        OUT_READY = 1'b0;

`ifdef OUT_CHANGE_FIFO_TS_EN
        // Sample at the 11th posedge after release carries timestamp 10.
        do_reset();
        repeat (10) step();
        expq.push_back(8'h0A);
        sample(8'h0A);
        IN_EN = 1'b0;
        chk("ts_out", OUT, 8'h0A);
        chk("ts_value", OUT_TS, 10);
        OUT_READY = 1'b1;
        step();
        OUT_READY = 1'b0;
`endif

        repeat (2) step();
        chk("queue_empty", expq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
